// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - per-bit synchronised edge detector with pulse stretch, counter and sticky flags
// Optional sticky/irq logic is built only when MULTI_EDGE_DETECTOR_STICKY_EN is defined.
module multi_edge_detector #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] pulse,
  output logic [WIDTH-1:0] sticky,
  output logic             irq,
  output logic [CNT_W-1:0] edge_count
);

  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);
  localparam logic [7:0] PLEN       = 8'(PULSE_LEN);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] hist_q;
  logic [2:0]       prime_cnt;
  logic             primed;
  logic [WIDTH-1:0] raw_edge;
  logic [WIDTH-1:0] det_edge;
  logic             any_edge;
  logic [7:0]       pulse_cnt [WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Masks the spurious edge seen while the reset-time zeros drain out of the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prime_cnt <= '0;
    end else if (prime_cnt != PRIME_DONE) begin
      prime_cnt <= prime_cnt + 3'd1;
    end
  end

  assign primed = (prime_cnt == PRIME_DONE);

  always_comb begin
    raw_edge = '0;
    case (mode)
      2'b01:   raw_edge = sync_q[SYNC_STAGES-1] & ~hist_q;
      2'b10:   raw_edge = ~sync_q[SYNC_STAGES-1] & hist_q;
      2'b11:   raw_edge = sync_q[SYNC_STAGES-1] ^ hist_q;
      default: raw_edge = '0;
    endcase
  end

  assign det_edge = primed ? raw_edge : '0;
  assign any_edge = |det_edge;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) pulse_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (det_edge[i]) begin
          pulse_cnt[i] <= PLEN;
        end else if (pulse_cnt[i] != 8'd0) begin
          pulse_cnt[i] <= pulse_cnt[i] - 8'd1;
        end
      end
    end
  end

  always_comb begin
    pulse = '0;
    for (int i = 0; i < WIDTH; i++) pulse[i] = (pulse_cnt[i] != 8'd0);
  end

  // Clear and count in the same cycle resolves to a count of one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_count <= '0;
    end else if (cnt_clr) begin
      edge_count <= any_edge ? CNT_W'(1) : '0;
    end else if (any_edge && (edge_count != '1)) begin
      edge_count <= edge_count + CNT_W'(1);
    end
  end

`ifdef MULTI_EDGE_DETECTOR_STICKY_EN
  logic [WIDTH-1:0] sticky_q;
  logic             irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      sticky_q <= (sticky_q & ~clr) | det_edge;
      irq_q    <= (sticky_q != '0);
    end
  end

  assign sticky = sticky_q;
  assign irq    = irq_q;
`else
  logic unused_clr;
  assign unused_clr = ^clr;
  assign sticky     = '0;
  assign irq        = 1'b0;
`endif

endmodule
